// File: rtl/transpose_buffer_pkg.sv
// Shared constants, FSM state type and range helper for the transpose buffer.
package transpose_buffer_pkg;

  localparam int WORD_W = 4;
  localparam int IDX_W  = 3;
  localparam int DEPTH  = 2 ** (2 * IDX_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  // Last valid index for a range field; a range of 0 encodes 8, so it wraps to 7.
  function automatic logic [IDX_W-1:0] range_limit(input logic [IDX_W-1:0] range);
    return range - IDX_W'(1);
  endfunction

endpackage

// File: rtl/transpose_index_counter.sv
// Wrap counter: steps on advance and returns to 0 after reaching limit.
// Shared by the writer (inner/outer indices) and usable by the reader.
module transpose_index_counter
  import transpose_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic [IDX_W-1:0] limit,
  output logic [IDX_W-1:0] idx,
  output logic             at_limit
);

  assign at_limit = (idx == limit);

  // Index register: wrap to 0 once the limit has been consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (advance) begin
      idx <= at_limit ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/transpose_buffer_writer.sv
// Producer side of the transpose buffer: packs a valid/ready word stream into
// a DEPTH x WORD_W array addressed {outer, inner} and hands the full block to
// the reader through out_valid/out_ack.
// Optional build macro: TRANSPOSE_WRITER_CLEAR_EN clears the array when a
// block is acknowledged, so each new block starts from all zeros.
module transpose_buffer_writer
  import transpose_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [IDX_W-1:0]  range_inner,
  input  logic [IDX_W-1:0]  range_outer,
  output logic [WORD_W-1:0] output_data [DEPTH-1:0],
  output logic              out_valid,
  input  logic              out_ack,
  output logic [IDX_W-1:0]  write_inner,
  output logic [IDX_W-1:0]  write_outer
);

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] inner_range_reg;
  logic [IDX_W-1:0] outer_range_reg;
  logic [IDX_W-1:0] inner_limit;
  logic [IDX_W-1:0] outer_limit;
  logic             inner_at_limit;
  logic             outer_at_limit;
  logic             accept;
  logic             last_word;

  // Handshake outputs depend only on the state, keeping accept free of loops.
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg == FULL);
  assign accept    = in_valid && in_ready;

  // The first word of a block must already see the live ranges, since the
  // latched copy only updates on that same edge.
  assign inner_limit = (state_reg == IDLE) ? range_limit(range_inner) : range_limit(inner_range_reg);
  assign outer_limit = (state_reg == IDLE) ? range_limit(range_outer) : range_limit(outer_range_reg);
  assign last_word   = inner_at_limit && outer_at_limit;

  transpose_index_counter u_inner (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (accept),
    .limit    (inner_limit),
    .idx      (write_inner),
    .at_limit (inner_at_limit)
  );

  transpose_index_counter u_outer (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (accept && inner_at_limit),
    .limit    (outer_limit),
    .idx      (write_outer),
    .at_limit (outer_at_limit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a block completes on its last accepted word.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept) state_next = last_word ? FULL : FILL;
      FILL: if (accept && last_word) state_next = FULL;
      FULL: if (out_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ranges are captured once per block, on its first accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_range_reg <= '0;
      outer_range_reg <= '0;
    end else if (state_reg == IDLE && accept) begin
      inner_range_reg <= range_inner;
      outer_range_reg <= range_outer;
    end
  end

  // Array storage: one write per accepted word, frozen while FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) output_data[i] <= '0;
    end else begin
      if (accept) output_data[{write_outer, write_inner}] <= in_data;
`ifdef TRANSPOSE_WRITER_CLEAR_EN
      if (state_reg == FULL && out_ack) begin
        for (int i = 0; i < DEPTH; i++) output_data[i] <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_transpose_buffer_writer.sv
// Self-checking bench for transpose_buffer_writer: directed cases plus random
// blocks, with a scoreboard checking each completed block's array contents.
module tb_transpose_buffer_writer;
  import transpose_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ack = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic [2:0] range_inner = 3'd0;
  logic [2:0] range_outer = 3'd0;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] write_inner;
  logic [2:0] write_outer;
  logic [3:0] output_data [63:0];

  int checks = 0;
  int failures = 0;

  // Reference array: what the 64 entries should hold right now.
  logic [3:0]   model [64];
  logic [255:0] exp_q [$];
  bit           seen_valid = 0;

  transpose_buffer_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .range_inner (range_inner),
    .range_outer (range_outer),
    .output_data (output_data),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .write_inner (write_inner),
    .write_outer (write_outer)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pack_model();
    logic [255:0] v;
    for (int k = 0; k < 64; k++) v[k*4 +: 4] = model[k];
    return v;
  endfunction

  function automatic logic [255:0] pack_dut();
    logic [255:0] v;
    for (int k = 0; k < 64; k++) v[k*4 +: 4] = output_data[k];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic arr_chk(input string nm);
    logic [255:0] a;
    logic [255:0] e;
    a = pack_dut();
    e = pack_model();
    checks++;
    if (a !== e) begin
      failures++;
      for (int k = 0; k < 64; k++) begin
        if (a[k*4 +: 4] !== e[k*4 +: 4]) begin
          $display("FAIL %s entry=%0d act=%0h exp=%0h t=%0t", nm, k, a[k*4 +: 4], e[k*4 +: 4], $time);
          break;
        end
      end
    end
  endtask

  function automatic void clear_model();
    for (int k = 0; k < 64; k++) model[k] = 4'h0;
  endfunction

  // Scoreboard monitor: on each rising out_valid, compare the whole array.
  always @(negedge clk) begin
    logic [255:0] e;
    logic [255:0] a;
    if (rst_n && out_valid && !seen_valid) begin
      seen_valid = 1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_block act=out_valid exp=no_block t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        a = pack_dut();
        if (a !== e) begin
          failures++;
          $display("FAIL sb_block act=%h exp=%h", a, e);
        end else begin
          $display("block ok t=%0t", $time);
        end
      end
    end
    if (!out_valid) seen_valid = 0;
  end

  // Stream one block. mode: 0 random, 1 address%16, 2 constant c, 3 word count.
  // abort_after>0 stops after that many words (block left incomplete).
  task automatic send_block(input logic [2:0] ri, input logic [2:0] ro, input int mode,
                            input logic [3:0] c, input bit change_mid, input int abort_after,
                            input bit bubbles);
    int ei;
    int eo;
    int n;
    int addr;
    logic [3:0] d;
    ei = (ri == 0) ? 8 : int'(ri);
    eo = (ro == 0) ? 8 : int'(ro);
    n = 0;
    range_inner = ri;
    range_outer = ro;
    for (int o = 0; o < eo; o++) begin
      for (int i = 0; i < ei; i++) begin
        addr = o * 8 + i;
        case (mode)
          0: d = 4'($urandom);
          1: d = 4'(addr % 16);
          2: d = c;
          default: d = 4'(n + 1);
        endcase
        if (bubbles) begin
          while ($urandom_range(0, 3) == 0) begin
            in_valid = 0;
            @(negedge clk);
          end
        end
        chk("idx_inner", write_inner, i);
        chk("idx_outer", write_outer, o);
        chk("ready_in_fill", in_ready, 1);
        chk("valid_early", out_valid, 0);
        in_valid = 1;
        in_data = d;
        @(posedge clk);
        model[addr] = d;
        n++;
        if (n == ei * eo) exp_q.push_back(pack_model());
        @(negedge clk);
        in_valid = 0;
        chk("latency1", output_data[addr], d);
        $display("word n=%0d addr=%0d data=%0h", n, addr, d);
        if (change_mid && n == 2) begin
          range_inner = 3'd1;
          range_outer = 3'd1;
        end
        if (n == abort_after) return;
      end
    end
    chk("valid_after_last", out_valid, 1);
    chk("ready_full", in_ready, 0);
    chk("wrap_inner", write_inner, 0);
    chk("wrap_outer", write_outer, 0);
  endtask

  // Hold a word against a full block: it must not be consumed.
  task automatic hold_full(input int cycles);
    in_valid = 1;
    in_data = 4'hF;
    repeat (cycles) begin
      @(negedge clk);
      chk("full_ready", in_ready, 0);
      chk("full_valid", out_valid, 1);
    end
    in_valid = 0;
    arr_chk("full_frozen");
    chk("full_idx_inner", write_inner, 0);
  endtask

  task automatic do_ack(input int delay);
    repeat (delay) @(negedge clk);
    out_ack = 1;
    @(posedge clk);
`ifdef TRANSPOSE_WRITER_CLEAR_EN
    clear_model();
`endif
    @(negedge clk);
    out_ack = 0;
    chk("ack_valid", out_valid, 0);
    chk("ack_ready", in_ready, 1);
    arr_chk("after_ack");
    $display("ack done t=%0t", $time);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_inner", write_inner, 0);
    chk("rst_outer", write_outer, 0);
    arr_chk("rst_array");
    rst_n = 1;
    @(negedge clk);

    // 2x2 block of 1,2,3,4.
    send_block(3'd2, 3'd2, 3, 4'h0, 0, -1, 0);
    chk("t1_e0", output_data[0], 1);
    chk("t1_e1", output_data[1], 2);
    chk("t1_e8", output_data[8], 3);
    chk("t1_e9", output_data[9], 4);
    hold_full(3);
    do_ack(0);

    // Ack outside FULL is ignored.
    out_ack = 1;
    @(negedge clk);
    out_ack = 0;
    chk("idle_ack_ready", in_ready, 1);
    chk("idle_ack_valid", out_valid, 0);
    arr_chk("idle_ack_array");

    // Full 8x8 block via range 0/0.
    send_block(3'd0, 3'd0, 1, 4'h0, 0, -1, 0);
    for (int k = 0; k < 64; k += 9) chk("t3_entry", output_data[k], k % 16);
    do_ack(1);

    // Ranges 3/2 latched, inputs changed to 1/1 mid-block.
    send_block(3'd3, 3'd2, 0, 4'h0, 1, -1, 0);
    chk("t4_e10", output_data[10], model[10]);
    do_ack(2);

    // Asynchronous reset after word 3 of a 4x4 block.
    send_block(3'd4, 3'd4, 2, 4'h7, 0, 3, 0);
    #2;
    rst_n = 0;
    #1;
    clear_model();
    chk("arst_ready", in_ready, 1);
    chk("arst_valid", out_valid, 0);
    chk("arst_inner", write_inner, 0);
    chk("arst_outer", write_outer, 0);
    arr_chk("arst_array");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send_block(3'd2, 3'd2, 0, 4'h0, 0, -1, 0);
    do_ack(0);

    // Stale entries after a smaller block.
    send_block(3'd2, 3'd2, 2, 4'hA, 0, -1, 0);
    do_ack(0);
    send_block(3'd1, 3'd1, 2, 4'h5, 0, -1, 0);
    chk("t6_e0", output_data[0], 4'h5);
`ifdef TRANSPOSE_WRITER_CLEAR_EN
    chk("t6_e1", output_data[1], 4'h0);
    chk("t6_e9", output_data[9], 4'h0);
`else
    chk("t6_e1", output_data[1], 4'hA);
    chk("t6_e9", output_data[9], 4'hA);
`endif
    do_ack(0);

    // Random blocks with input bubbles and ack delays.
    repeat (8) begin
      send_block(3'($urandom), 3'($urandom), 0, 4'h0, 0, -1, 1);
      hold_full($urandom_range(0, 2));
      do_ack($urandom_range(0, 3));
    end

    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
